// File: rtl/add_sequencer.sv
// Multi-cycle wide-word adder: drives one external 4-bit adder nibble by nibble, LSB first.
// Optional subtract support is compiled in when ADD_SEQ_SUB_EN is defined.
module add_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   A,
  input  logic [4*NIBBLES-1:0]   B,
  input  logic                   CarryIN,
  input  logic                   SUB,
  output logic [3:0]             ADD_A,
  output logic [3:0]             ADD_B,
  output logic                   ADD_CIN,
  input  logic [3:0]             ADD_Y,
  input  logic                   ADD_COUT,
  input  logic                   ADD_OVF,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   RESULT,
  output logic                   CarryOUT,
  output logic                   overflow,
  output logic                   zero,
  output logic [1:0]             dbgState
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  // Handshake: start is accepted on any edge where the FSM is not in RUN
  // (IDLE or DONE); operands are latched on that same edge and never again until done.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t         state, stateNext;
  logic [W-1:0]   opA, opB, acc, sumWord;
  logic [IW-1:0]  idx;
  logic           carry;
  logic           accept, lastNib, initCarry;
  logic [3:0]     nibA, nibB;

`ifdef ADD_SEQ_SUB_EN
  logic subReg;
  assign initCarry = SUB ? 1'b1 : CarryIN;
`else
  logic unusedSub;
  assign unusedSub = SUB;
  assign initCarry = CarryIN;
`endif

  assign accept   = start && (state != RUN);
  assign lastNib  = (idx == IW'(NIBBLES - 1));
  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign dbgState = state;

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = RUN;
      RUN:     if (lastNib) stateNext = DONE;
      DONE:    stateNext = start ? RUN : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Nibble select for the adder and the accumulator image including this cycle's sum.
  always_comb begin
    nibA    = 4'd0;
    nibB    = 4'd0;
    sumWord = acc;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        nibA = opA[i*4 +: 4];
        nibB = opB[i*4 +: 4];
        sumWord[i*4 +: 4] = ADD_Y;
      end
    end
  end

  always_comb begin
    ADD_A   = 4'd0;
    ADD_B   = 4'd0;
    ADD_CIN = 1'b0;
    if (state == RUN) begin
      ADD_A   = nibA;
`ifdef ADD_SEQ_SUB_EN
      ADD_B   = subReg ? ~nibB : nibB;
`else
      ADD_B   = nibB;
`endif
      ADD_CIN = carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      opA      <= '0;
      opB      <= '0;
      acc      <= '0;
      RESULT   <= '0;
      CarryOUT <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
`ifdef ADD_SEQ_SUB_EN
      subReg   <= 1'b0;
`endif
    end else begin
      state <= stateNext;
      if (accept) begin
        opA   <= A;
        opB   <= B;
        idx   <= '0;
        carry <= initCarry;
`ifdef ADD_SEQ_SUB_EN
        subReg <= SUB;
`endif
      end else if (state == RUN) begin
        acc   <= sumWord;
        carry <= ADD_COUT;
        idx   <= idx + IW'(1);
        if (lastNib) begin
          RESULT   <= sumWord;
          CarryOUT <= ADD_COUT;
          overflow <= ADD_OVF;
          zero     <= (sumWord == '0);
        end
      end
    end
  end
endmodule

// File: tb/tb_add_sequencer.sv
// Bench for add_sequencer: behavioural 4-bit adder stand-in plus a word-level
// reference model; directed test-plan vectors followed by random operations.
module tb_add_sequencer;
  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic          clk, rst, start, CarryIN, SUB;
  logic [W-1:0]  A, B, RESULT;
  logic [3:0]    ADD_A, ADD_B, ADD_Y;
  logic          ADD_CIN, ADD_COUT, ADD_OVF;
  logic          busy, done, CarryOUT, overflow, zero;
  logic [1:0]    dbgState;

  int checks = 0;
  int errors = 0;
  logic [W+2:0] exp_q[$];
  logic [W+2:0] held;

  add_sequencer #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .CarryIN(CarryIN), .SUB(SUB),
    .ADD_A(ADD_A), .ADD_B(ADD_B), .ADD_CIN(ADD_CIN), .ADD_Y(ADD_Y),
    .ADD_COUT(ADD_COUT), .ADD_OVF(ADD_OVF), .busy(busy), .done(done),
    .RESULT(RESULT), .CarryOUT(CarryOUT), .overflow(overflow), .zero(zero),
    .dbgState(dbgState)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the 4-bit addition unit.
  always_comb begin
    {ADD_COUT, ADD_Y} = {1'b0, ADD_A} + {1'b0, ADD_B} + {4'd0, ADD_CIN};
    ADD_OVF = (ADD_A[3] == ADD_B[3]) && (ADD_Y[3] != ADD_A[3]);
  end

  // Word-level reference: {zero, overflow, carryOut, result}
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] bop;
    logic         c0;
    logic [W:0]   s;
    logic         ovf;
    bop = b;
    c0  = cin;
`ifdef ADD_SEQ_SUB_EN
    if (sub) begin
      bop = ~b;
      c0  = 1'b1;
    end
`else
    if (sub) c0 = cin;
`endif
    s   = {1'b0, a} + {1'b0, bop} + {{W{1'b0}}, c0};
    ovf = (a[W-1] == bop[W-1]) && (s[W-1] != a[W-1]);
    return {(s[W-1:0] == '0), ovf, s[W], s[W-1:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic checkOutputs(input string tag, input logic [W+2:0] e);
    check({tag, "_result"},   64'(RESULT),   64'(e[W-1:0]));
    check({tag, "_carryout"}, 64'(CarryOUT), 64'(e[W]));
    check({tag, "_overflow"}, 64'(overflow), 64'(e[W+1]));
    check({tag, "_zero"},     64'(zero),     64'(e[W+2]));
  endtask

  // Driver: called at a negedge; returns at the negedge of the DONE cycle.
  // midStart pulses start with other operands during RUN (must be ignored).
  task automatic runOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub, input bit midStart);
    logic [W+2:0] e;
    A = a; B = b; CarryIN = cin; SUB = sub; start = 1'b1;
    exp_q.push_back(model(a, b, cin, sub));
    for (int c = 0; c < NIB; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (midStart && c == 1) begin
        start = 1'b1;
        A = W'($urandom);
        B = W'($urandom);
      end
      check({tag, "_busy"}, 64'(busy), 64'd1);
      check({tag, "_nodone"}, 64'(done), 64'd0);
      checkOutputs({tag, "_hold"}, held);
    end
    start = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_notbusy"}, 64'(busy), 64'd0);
    checkOutputs(tag, e);
    held = e;
  endtask

  task automatic idleCycle(input string tag);
    @(negedge clk);
    check({tag, "_idle_done"}, 64'(done), 64'd0);
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    check({tag, "_idle_ports"}, 64'({ADD_A, ADD_B, ADD_CIN}), 64'd0);
    checkOutputs({tag, "_idle"}, held);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; B = '0; CarryIN = 1'b0; SUB = 1'b0;
    held = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_state", 64'(dbgState), 64'd0);
    check("reset_ports", 64'({ADD_A, ADD_B, ADD_CIN}), 64'd0);
    checkOutputs("reset", '0);
    rst = 1'b0;
    idleCycle("post_reset");

    // Directed test-plan vectors
    runOp("basic_add", 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
    check("basic_add_const", 64'(RESULT), 64'h2345);
    idleCycle("basic_add");
    runOp("carry_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    check("carry_ripple_const", 64'({zero, CarryOUT, RESULT}), 64'h3_0000);
    idleCycle("carry_ripple");
    runOp("signed_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    check("signed_ovf_const", 64'({overflow, CarryOUT, RESULT}), 64'h2_8000);
    idleCycle("signed_ovf");
    runOp("cin_add", 16'h0003, 16'h0004, 1'b1, 1'b0, 1'b0);
    check("cin_add_const", 64'(RESULT), 64'h0008);
    idleCycle("cin_add");

    // start during RUN ignored; then start held in DONE gives back-to-back
    runOp("mid_start", 16'h0102, 16'h0304, 1'b0, 1'b0, 1'b1);
    check("mid_start_const", 64'(RESULT), 64'h0406);
    runOp("back2back", 16'hABCD, 16'h1111, 1'b1, 1'b0, 1'b0);
    idleCycle("back2back");

    // Subtract (expectation depends on whether the feature is built)
    runOp("subtract", 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
`ifdef ADD_SEQ_SUB_EN
    check("subtract_const", 64'({CarryOUT, RESULT}), 64'h0_FFFE);
`else
    check("subtract_const", 64'(RESULT), 64'h000C);
`endif
    idleCycle("subtract");

    // Reset after 2 RUN cycles discards the operation
    A = 16'h4444; B = 16'h2222; CarryIN = 1'b0; SUB = 1'b0; start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    check("midrst_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    held = '0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_state", 64'(dbgState), 64'd0);
    checkOutputs("midrst", '0);
    for (int c = 0; c < NIB + 2; c++) idleCycle("midrst_nodone");

    // Random operations, randomly back-to-back
    for (int n = 0; n < 24; n++) begin
      runOp("random", W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idleCycle("random");
    end
    idleCycle("final");
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
